// File: rtl/cache_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cache_pkg                                                            |
// | Shared widths, refill entry layout and FSM state encoding for the    |
// | direct-mapped cache lookup controller.                               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package cache_pkg;

  localparam int TAG_W   = 18;
  localparam int IDX_W   = 9;
  localparam int LINE_W  = 256;
  localparam int ENTRY_W = 1 + TAG_W + LINE_W;

  // Layout matches the refill bus: {valid, tag, word7..word0}
  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] data;
  } cache_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOOKUP    = 2'd1,
    ST_MISS_WAIT = 2'd2,
    ST_RESP      = 2'd3
  } state_t;

  // Pick one 32-bit word out of a line; the word index is scaled to a bit offset
  function automatic logic [31:0] line_word(input logic [LINE_W-1:0] line,
                                            input logic [2:0]        sel);
    return line[{sel, 5'b0_0000} +: 32];
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_tag_data_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cache_tag_data_array                                                 |
// | Tag/data storage with one read port (registered read), one write     |
// | port, and per-line valid bits cleared together in a single reset     |
// | cycle. Tag and data RAMs are not reset.                              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module cache_tag_data_array
  import cache_pkg::*;
#(
  parameter int IDX_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output cache_entry_t     rd_entry,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  cache_entry_t     wr_entry
);

  localparam int DEPTH = 1 << IDX_W;

  logic [TAG_W-1:0]  tag_mem_q  [DEPTH];
  logic [LINE_W-1:0] data_mem_q [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  cache_entry_t      rd_entry_q, rd_entry_d;

  // Valid bit follows the refill's own valid field
  always_comb begin
    valid_d = valid_q;
    if (wr_en) begin
      valid_d[wr_idx] = wr_entry.valid;
    end
  end

  // All valid bits drop in the same cycle reset is seen
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data RAM write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem_q[wr_idx]  <= wr_entry.tag;
      data_mem_q[wr_idx] <= wr_entry.data;
    end
  end

  // Read data is captured on rd_en and held until the next read
  always_comb begin
    rd_entry_d = rd_entry_q;
    if (rd_en) begin
      rd_entry_d = '{valid: valid_q[rd_idx], tag: tag_mem_q[rd_idx], data: data_mem_q[rd_idx]};
    end
  end

  // Registered read port
  always_ff @(posedge clk) begin
    rd_entry_q <= rd_entry_d;
  end

  assign rd_entry = rd_entry_q;

endmodule
`default_nettype wire

// File: rtl/cache_lookup_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cache_lookup_ctrl                                                    |
// | Direct-mapped read-only cache lookup FSM: accepts one CPU load at a  |
// | time, answers hits two cycles after acceptance, otherwise raises a   |
// | refill request and forwards the refilled word.                       |
// | Optional build macro CACHE_STATS_EN adds hit/miss counters.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module cache_lookup_ctrl
  import cache_pkg::*;
#(
  parameter int IDX_W      = 9,
  parameter int LINE_WORDS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_rd_req,
  input  logic [31:0]        cpu_addr,
  output logic               cpu_stall,
  output logic               cpu_rd_valid,
  output logic [31:0]        cpu_rd_data,
  output logic               rd_miss,
  output logic [31:0]        miss_addr,
  input  logic               upd_entry,
  input  logic [ENTRY_W-1:0] entry_upd_val
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]        hit_cnt,
  output logic [31:0]        miss_cnt
`endif
);

  localparam int WSEL_W = $clog2(LINE_WORDS);
  localparam int OFF_W  = WSEL_W + 2;

  state_t       state_q, state_d;
  logic [31:0]  addr_q, addr_d;
  logic         rd_valid_q, rd_valid_d;
  logic [31:0]  rd_data_q, rd_data_d;
  logic         rd_miss_q, rd_miss_d;
  logic [31:0]  miss_addr_q, miss_addr_d;

  logic         arr_rd_en;
  logic         arr_wr_en;
  cache_entry_t arr_rd_entry;
  cache_entry_t refill;
  logic         lookup_hit;

  assign refill     = cache_entry_t'(entry_upd_val);
  assign lookup_hit = arr_rd_entry.valid && (arr_rd_entry.tag == addr_q[31 -: TAG_W]);

  // The read is launched on the accepting edge with the incoming index (the
  // same value being latched), so the registered entry is ready in LOOKUP.
  assign arr_rd_en = (state_q == ST_IDLE) && cpu_rd_req;
  // A refill landing in the reset cycle is dropped along with the request
  assign arr_wr_en = (state_q == ST_MISS_WAIT) && upd_entry && !rst;

  cache_tag_data_array #(
    .IDX_W (IDX_W)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_en    (arr_rd_en),
    .rd_idx   (cpu_addr[OFF_W +: IDX_W]),
    .rd_entry (arr_rd_entry),
    .wr_en    (arr_wr_en),
    .wr_idx   (addr_q[OFF_W +: IDX_W]),
    .wr_entry (refill)
  );

  // Next-state and registered-output logic for the lookup FSM
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rd_valid_d  = 1'b0;
    rd_data_d   = rd_data_q;
    rd_miss_d   = rd_miss_q;
    miss_addr_d = miss_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (cpu_rd_req) begin
          addr_d  = cpu_addr;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (lookup_hit) begin
          state_d    = ST_RESP;
          rd_valid_d = 1'b1;
          rd_data_d  = line_word(arr_rd_entry.data, addr_q[OFF_W-1:2]);
        end else begin
          state_d     = ST_MISS_WAIT;
          rd_miss_d   = 1'b1;
          miss_addr_d = addr_q;
        end
      end
      ST_MISS_WAIT: begin
        if (upd_entry) begin
          // Refilled word is forwarded straight from the refill bus
          state_d    = ST_RESP;
          rd_miss_d  = 1'b0;
          rd_valid_d = 1'b1;
          rd_data_d  = line_word(refill.data, addr_q[OFF_W-1:2]);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_miss_q   <= 1'b0;
      miss_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      rd_miss_q   <= rd_miss_d;
      miss_addr_q <= miss_addr_d;
    end
  end

  assign cpu_stall    = (state_q != ST_IDLE);
  assign cpu_rd_valid = rd_valid_q;
  assign cpu_rd_data  = rd_data_q;
  assign rd_miss      = rd_miss_q;
  assign miss_addr    = miss_addr_q;

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  // One count per LOOKUP outcome, saturating at all-ones
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == ST_LOOKUP) begin
      if (lookup_hit) begin
        if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_d = hit_cnt_q + 32'd1;
      end else begin
        if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
      end
    end
  end

  // Statistics counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_lookup_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cache_lookup_ctrl                                                 |
// | Randomized scoreboard bench for cache_lookup_ctrl. A line-level      |
// | cache model predicts each response; a monitor pops and compares.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_cache_lookup_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cpu_rd_req = 1'b0;
  logic [31:0]  cpu_addr = '0;
  logic         cpu_stall;
  logic         cpu_rd_valid;
  logic [31:0]  cpu_rd_data;
  logic         rd_miss;
  logic [31:0]  miss_addr;
  logic         upd_entry = 1'b0;
  logic [274:0] entry_upd_val = '0;
`ifdef CACHE_STATS_EN
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;
`endif

  cache_lookup_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_rd_req    (cpu_rd_req),
    .cpu_addr      (cpu_addr),
    .cpu_stall     (cpu_stall),
    .cpu_rd_valid  (cpu_rd_valid),
    .cpu_rd_data   (cpu_rd_data),
    .rd_miss       (rd_miss),
    .miss_addr     (miss_addr),
    .upd_entry     (upd_entry),
    .entry_upd_val (entry_upd_val)
`ifdef CACHE_STATS_EN
    ,
    .hit_cnt       (hit_cnt),
    .miss_cnt      (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: one line per index
  bit           m_valid [512];
  logic [17:0]  m_tag   [512];
  logic [255:0] m_data  [512];
  int           m_hits = 0;
  int           m_misses = 0;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [255:0] line, input int w);
    logic [255:0] sh;
    sh = line >> (32 * w);
    return sh[31:0];
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [274:0] make_entry(input bit v, input logic [17:0] t, input logic [255:0] d);
    return {v, t, d};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 512; i++) m_valid[i] = 1'b0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic check_stats();
`ifdef CACHE_STATS_EN
    check("hit_cnt", hit_cnt, m_hits);
    check("miss_cnt", miss_cnt, m_misses);
`endif
  endtask

  // Drive don't-care traffic while the controller is busy
  task automatic drive_junk(input bit allow_upd);
    cpu_rd_req    = 1'($urandom_range(0, 1));
    cpu_addr      = $urandom;
    upd_entry     = allow_upd ? 1'($urandom_range(0, 1)) : 1'b0;
    entry_upd_val = make_entry(1'b1, 18'($urandom), rand_line());
  endtask

  // Monitor: every response pulse must match the oldest prediction
  always @(negedge clk) begin
    if (cpu_rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rd_valid got=%h want=no_response cycle=%0d", cpu_rd_data, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("rd_data", cpu_rd_data, mon_e.data);
        check("rd_valid_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic apply_reset(input int n);
    @(negedge clk);
    rst = 1'b1; cpu_rd_req = 1'b0; upd_entry = 1'b0;
    repeat (n) @(negedge clk);
    check("rst_stall", cpu_stall, 0);
    check("rst_rd_valid", cpu_rd_valid, 0);
    check("rst_rd_miss", rd_miss, 0);
    check("rst_miss_addr", miss_addr, 0);
    check("rst_rd_data", cpu_rd_data, 0);
    model_clear();
    check_stats();
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      cpu_rd_req    = 1'b0;
      upd_entry     = 1'($urandom_range(0, 1));
      entry_upd_val = make_entry(1'b1, 18'($urandom_range(0, 3)), rand_line());
    end
  endtask

  // One load; on a predicted miss the handler answers with `fill` after wait_cyc cycles
  task automatic do_read(input logic [31:0] addr, input logic [274:0] fill, input int wait_cyc);
    int idx;
    int w;
    bit hit;
    int c;
    idx = int'(addr[13:5]);
    w   = int'(addr[4:2]);
    hit = m_valid[idx] && (m_tag[idx] == addr[31:14]);
    @(negedge clk);
    check("stall_idle", cpu_stall, 0);
    cpu_rd_req = 1'b1; cpu_addr = addr; upd_entry = 1'b0;
    c = cyc;
    if (hit) begin
      m_hits++;
      exp_q.push_back('{data: word_of(m_data[idx], w), cyc: c + 2});
      @(negedge clk);
      check("stall_lookup", cpu_stall, 1);
      drive_junk(1'b1);
      @(negedge clk);
      check("miss_on_hit", rd_miss, 0);
      drive_junk(1'b1);
    end else begin
      m_misses++;
      @(negedge clk);
      check("stall_lookup", cpu_stall, 1);
      drive_junk(1'b1);
      @(negedge clk);
      for (int k = 0; k <= wait_cyc; k++) begin
        if (k > 0) @(negedge clk);
        check("rd_miss_held", rd_miss, 1);
        check("miss_addr", miss_addr, addr);
        check("stall_miss", cpu_stall, 1);
        drive_junk(1'b0);
      end
      upd_entry     = 1'b1;
      entry_upd_val = fill;
      exp_q.push_back('{data: word_of(fill[255:0], w), cyc: cyc + 1});
      m_valid[idx] = fill[274];
      m_tag[idx]   = fill[273:256];
      m_data[idx]  = fill[255:0];
      @(negedge clk);
      check("rd_miss_drop", rd_miss, 0);
      drive_junk(1'b1);
    end
    check_stats();
  endtask

  // Reset arrives while a refill is outstanding; a late refill must be ignored
  task automatic miss_then_reset(input logic [31:0] addr);
    @(negedge clk);
    check("stall_idle", cpu_stall, 0);
    cpu_rd_req = 1'b1; cpu_addr = addr; upd_entry = 1'b0;
    @(negedge clk);
    drive_junk(1'b1);
    @(negedge clk);
    check("rd_miss_before_rst", rd_miss, 1);
    cpu_rd_req = 1'b0; upd_entry = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("rd_miss_after_rst", rd_miss, 0);
    check("stall_after_rst", cpu_stall, 0);
    rst = 1'b0;
    model_clear();
    upd_entry     = 1'b1;
    entry_upd_val = make_entry(1'b1, addr[31:14], rand_line());
    @(negedge clk);
    upd_entry = 1'b0;
    check("stall_late_upd", cpu_stall, 0);
    @(negedge clk);
    check("stall_late_upd2", cpu_stall, 0);
    check_stats();
  endtask

  logic [255:0] line;
  logic [31:0]  raddr;
  logic [17:0]  ftag;

  initial begin
    apply_reset(3);

    // Cold miss, refill index 2 tag 0 with word0 = DEADBEEF
    line = rand_line();
    line[31:0] = 32'hDEAD_BEEF;
    do_read(32'h0000_0040, make_entry(1'b1, 18'd0, line), 3);
    // Hit on word1 of the same line
    do_read(32'h0000_0044, '0, 0);
    // Same index, tag 1: replaces the line; tag 0 then misses again
    do_read(32'h0000_4040, make_entry(1'b1, 18'd1, rand_line()), 1);
    do_read(32'h0000_0040, make_entry(1'b1, 18'd0, rand_line()), 0);
    do_read(32'h0000_005C, '0, 0);
    // Refill pulses in IDLE must not touch the array or counters
    idle(4);
    do_read(32'h0000_005C, '0, 0);
    do_read(32'h0000_4048, make_entry(1'b1, 18'd1, rand_line()), 0);

    // Reset in MISS_WAIT, then the same address misses
    miss_then_reset(32'h0000_0080);
    do_read(32'h0000_0080, make_entry(1'b1, 18'd0, rand_line()), 2);
    do_read(32'h0000_0084, '0, 0);

    // Random traffic over a small tag/index pool so hits and conflicts are common
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 3))
        0: raddr[13:5] = 9'd0;
        1: raddr[13:5] = 9'd2;
        2: raddr[13:5] = 9'd511;
        default: raddr[13:5] = 9'($urandom_range(0, 7));
      endcase
      raddr[31:14] = 18'($urandom_range(0, 3));
      raddr[4:0]   = 5'($urandom);
      ftag = ($urandom_range(0, 4) == 0) ? 18'($urandom_range(0, 3)) : raddr[31:14];
      do_read(raddr, make_entry($urandom_range(0, 9) != 0, ftag, rand_line()),
              int'($urandom_range(0, 3)));
      idle(int'($urandom_range(0, 2)));
    end

    idle(4);
    check("pending_responses", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cache_lookup_ctrl.md
CACHE_LOOKUP_CTRL -- requirements
Module: cache_lookup_ctrl

Interface
REQ-001 SHALL have parameter IDX_W, default 9, set-index width (512 direct-mapped lines).
REQ-002 SHALL have parameter LINE_WORDS, default 8, 32-bit words per line (32-byte line).
REQ-003 SHALL have port clk, input, 1, sole clock; all logic on posedge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port cpu_rd_req, input, 1, CPU load request.
REQ-006 SHALL have port cpu_addr, input, 32, byte address: tag [31:14], index [13:5], word [4:2].
REQ-007 SHALL have port cpu_stall, output, 1, request not accepted this cycle.
REQ-008 SHALL have port cpu_rd_valid, output, 1, one-cycle pulse qualifying cpu_rd_data.
REQ-009 SHALL have port cpu_rd_data, output, 32, load data.
REQ-010 SHALL have port rd_miss, output, 1, level refill request to the miss handler.
REQ-011 SHALL have port miss_addr, output, 32, latched missing address.
REQ-012 SHALL have port upd_entry, input, 1, refill-complete pulse from the miss handler.
REQ-013 SHALL have port entry_upd_val, input, 275, refill entry {valid[274], tag[273:256], word7..word0[255:0]}.

Function
REQ-014 SHALL implement FSM states IDLE, LOOKUP, MISS_WAIT, RESP.
REQ-015 SHALL drive cpu_stall = (state != IDLE), combinationally.
REQ-016 SHALL accept a request in IDLE when cpu_rd_req=1; it latches cpu_addr and moves to LOOKUP. Requests presented while cpu_stall=1 are ignored; the requester holds them.
REQ-017 SHALL read the array by the latched index in LOOKUP, then compare valid && tag == addr[31:14].
REQ-018 On hit, SHALL go to RESP; cpu_rd_valid=1 and cpu_rd_data=word[addr[4:2]] for exactly one cycle, 2 cycles after acceptance; then return to IDLE.
REQ-019 On miss, SHALL go to MISS_WAIT with rd_miss=1 and miss_addr=latched address, held constant until upd_entry.
REQ-020 In MISS_WAIT on upd_entry=1, SHALL write entry_upd_val to the latched index, deassert rd_miss the next cycle, and go to RESP.
REQ-021 In that RESP, SHALL return word[addr[4:2]] from the refilled entry, forwarded without re-reading the array.
REQ-022 SHALL ignore upd_entry outside MISS_WAIT: no array write and no state change.
REQ-023 SHALL write the refill's tag field as supplied, with no check against the latched tag.
REQ-024 SHALL fix word select to addr[4:2]; addr[1:0] ignored; no wrap beyond the line.
REQ-025 SHALL service back-to-back requests to the same index sequentially; the second sees the first's refill.

Reset
REQ-026 SHALL, while rst=1: state IDLE, cpu_rd_valid=0, rd_miss=0, miss_addr=0, cpu_rd_data=0, all 512 valid bits cleared; data and tag arrays not reset.
REQ-027 SHALL, on rst asserted mid-MISS_WAIT, drop rd_miss the next cycle and discard the pending request and any later upd_entry.

Configuration
REQ-028 SHALL support macro CACHE_STATS_EN; when defined, adds outputs hit_cnt[31:0] and miss_cnt[31:0].
REQ-029 Each counter SHALL increment once per LOOKUP outcome, saturate at 32'hFFFFFFFF, and reset to 0.
REQ-030 Without CACHE_STATS_EN, SHALL have neither counters nor ports; all other behaviour is identical.

Structure
REQ-031 SHALL take from shared package cache_pkg: TAG_W=18, IDX_W, LINE_W=256, ENTRY_W=275, packed struct cache_entry_t {valid, tag, data}, and the FSM state enum.
REQ-032 SHALL place storage in sub-module cache_tag_data_array: 1 read port, 1 write port, registered read, single-cycle valid clear.

Verification
REQ-033 SHALL cover: after reset, read 0x0000_0040 -> rd_miss=1, miss_addr=0x0000_0040, cpu_stall=1 until upd_entry.
REQ-034 SHALL cover: refill of index 2 with tag 0, word0=0xDEAD_BEEF -> cpu_rd_valid with 0xDEAD_BEEF; rd_miss low the cycle after upd_entry.
REQ-035 SHALL cover: repeat read 0x0000_0044 -> hit, cpu_rd_valid 2 cycles after acceptance, data=word1, rd_miss stays 0.
REQ-036 SHALL cover: read 0x0000_4040 (same index, tag 1) -> miss, refill replaces line; then 0x0000_0040 misses again.
REQ-037 SHALL cover: rst pulse during MISS_WAIT, then upd_entry -> no write, no cpu_rd_valid; next read of the same address misses.
REQ-038 SHALL cover: with CACHE_STATS_EN, 3 hits and 2 misses -> hit_cnt=3, miss_cnt=2; upd_entry pulsed in IDLE -> no counter or array change.
